// File: rtl/demux7_deserializer.sv
// +--------------------------------------------------------------------------+
// | demux7_deserializer: routes a serial bit stream into N_SLOTS output slots |
// | and presents the assembled frame on a valid/ready handshake.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module demux7_deserializer #(
    parameter int N_SLOTS   = 7,
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               serial_in,
    input  logic               in_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   demux_select,
    output logic [N_SLOTS-1:0] slot_strobe,
    output logic [N_SLOTS-1:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] c_first = (MSB_FIRST != 0) ? SEL_W'(N_SLOTS - 1) : '0;
    localparam logic [SEL_W-1:0] c_last  = (MSB_FIRST != 0) ? '0 : SEL_W'(N_SLOTS - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [N_SLOTS-1:0] r_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_overrun;

    logic               w_write;
    logic [SEL_W-1:0]   w_idx_next;
    logic [N_SLOTS-1:0] w_strobe;

    // A Start in the same cycle as a bit always wins; the bit is discarded.
    assign w_write    = (r_state == S_CAPTURE) && in_valid && !start;
    assign w_idx_next = (MSB_FIRST != 0) ? (r_idx - 1'b1) : (r_idx + 1'b1);

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_strobe
        assign w_strobe[k] = w_write && (r_idx == SEL_W'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= c_first;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CAPTURE;
                        r_busy    <= 1'b1;
                        r_idx     <= c_first;
                        r_overrun <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (start) begin
                        r_idx <= c_first;
                    end else if (in_valid) begin
                        r_out <= (r_out & ~w_strobe) | (w_strobe & {N_SLOTS{serial_in}});
                        if (r_idx == c_last) begin
                            r_idx       <= c_first;
                            r_state     <= S_HOLD;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_idx <= w_idx_next;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready && start) begin
                        r_state     <= S_CAPTURE;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_overrun   <= 1'b0;
                        r_idx       <= c_first;
                    end else begin
                        if (out_ready) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                        if (in_valid) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign demux_select = r_idx;
    assign slot_strobe  = w_strobe;
    assign out          = r_out;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
